// File: rtl/scene_pkg.sv
// scene_pkg: shared types and default constants for the scene sequencer.
//   state_e   - show state machine encoding (matches the 2-bit scene output)
//   speed_e   - speed selector encoding (x1, x2, x4; 3 is never produced)
//   speed_next/speed_step - speed cycling and per-frame step helpers
package scene_pkg;

  typedef enum logic [1:0] {
    StWait    = 2'd0,
    StFall    = 2'd1,
    StSwallow = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SpeedX1 = 2'd0,
    SpeedX2 = 2'd1,
    SpeedX4 = 2'd2
  } speed_e;

  localparam int unsigned WAIT_FRAMES    = 128;
  localparam int unsigned SWALLOW_FRAMES = 64;
  localparam int unsigned TEXT_Y_TOP     = 20;
  localparam int unsigned TEXT_Y_END     = 240;

  // x1 -> x2 -> x4 -> x1
  function automatic speed_e speed_next(speed_e s);
    case (s)
      SpeedX1: return SpeedX2;
      SpeedX2: return SpeedX4;
      default: return SpeedX1;
    endcase
  endfunction

  // step = 1 << speed_sel
  function automatic logic [7:0] speed_step(speed_e s);
    case (s)
      SpeedX2: return 8'd2;
      SpeedX4: return 8'd4;
      default: return 8'd1;
    endcase
  endfunction

endpackage

// File: rtl/scene_sequencer_if.sv
// scene_sequencer_if: bundles the sequencer's timing/button inputs and its
// per-frame animation outputs.
//   vsync, btn_pause, btn_speed, btn_skip : into the sequencer
//   frame_tick, ring_phase, text_y, text_visible, swallow, scene, paused,
//   speed_sel                               : out of the sequencer
// modport slave  - the sequencer side
// modport master - the environment side (timing generator, buttons, datapath)
interface scene_sequencer_if;

  logic       vsync;
  logic       btn_pause;
  logic       btn_speed;
  logic       btn_skip;
  logic       frame_tick;
  logic [7:0] ring_phase;
  logic [9:0] text_y;
  logic       text_visible;
  logic       swallow;
  logic [1:0] scene;
  logic       paused;
  logic [1:0] speed_sel;

  modport slave (
    input  vsync, btn_pause, btn_speed, btn_skip,
    output frame_tick, ring_phase, text_y, text_visible, swallow, scene, paused, speed_sel
  );

  modport master (
    output vsync, btn_pause, btn_speed, btn_skip,
    input  frame_tick, ring_phase, text_y, text_visible, swallow, scene, paused, speed_sel
  );

endinterface

// File: rtl/btn_debounce.sv
// btn_debounce: conditions one asynchronous push button.
//   clk, rst_n : clock and synchronous active-low reset
//   i_btn      : raw asynchronous button level
//   i_tick     : frame tick; the only moments the button is sampled
//   o_press    : one-cycle pulse (on a tick) when the debounced level rises
module btn_debounce (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  input  logic i_tick,
  output logic o_press
);

  logic r_sync1;
  logic r_sync2;
  logic r_sample;
  logic r_level;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_sample <= 1'b0;
      r_level  <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      if (i_tick) begin
        r_sample <= r_sync2;
        // Level only moves when two consecutive tick samples agree.
        if (r_sync2 == r_sample) begin
          r_level <= r_sync2;
        end
      end
    end
  end

  assign o_press = i_tick & r_sync2 & r_sample & ~r_level;

endmodule

// File: rtl/scene_sequencer.sv
// scene_sequencer: frame-rate controller for the black-hole renderer.
//   clk, rst_n : pixel clock, synchronous active-low reset
//   bus        : vsync and three buttons in; frame_tick, ring_phase, text_y,
//                text_visible, swallow, scene, paused, speed_sel out
// Every output register updates only in the frame_tick cycle, so the pixel
// datapath sees constant parameters for an entire frame.
module scene_sequencer
  import scene_pkg::*;
#(
  parameter int unsigned WaitFrames    = WAIT_FRAMES,
  parameter int unsigned SwallowFrames = SWALLOW_FRAMES,
  parameter int unsigned TextYTop      = TEXT_Y_TOP,
  parameter int unsigned TextYEnd      = TEXT_Y_END
) (
  input  logic              clk,
  input  logic              rst_n,
  scene_sequencer_if.slave  bus
);

  localparam logic [7:0]  WaitLast    = 8'(WaitFrames - 1);
  localparam logic [7:0]  SwallowLast = 8'(SwallowFrames - 1);
  localparam logic [9:0]  TextTop     = 10'(TextYTop);
  localparam logic [10:0] TextEnd     = 11'(TextYEnd);

  logic       r_vsync_q;
  logic       r_frame_tick;
  logic [7:0] r_ring_phase;
  logic [9:0] r_text_y;
  logic       r_text_visible;
  logic       r_swallow;
  state_e     r_state;
  logic       r_paused;
  speed_e     r_speed;
  logic [7:0] r_timer;

  logic       w_press_pause;
  logic       w_press_speed;
  logic       w_press_skip;

  logic [7:0]  w_ring_phase;
  logic [9:0]  w_text_y;
  logic        w_text_visible;
  logic        w_swallow;
  state_e      w_state;
  logic        w_paused;
  speed_e      w_speed;
  logic [7:0]  w_timer;
  logic [7:0]  w_step;
  logic [10:0] w_sum;

  btn_debounce u_db_pause (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_btn   (bus.btn_pause),
    .i_tick  (r_frame_tick),
    .o_press (w_press_pause)
  );

  btn_debounce u_db_speed (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_btn   (bus.btn_speed),
    .i_tick  (r_frame_tick),
    .o_press (w_press_speed)
  );

  btn_debounce u_db_skip (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_btn   (bus.btn_skip),
    .i_tick  (r_frame_tick),
    .o_press (w_press_skip)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // vsync_q resets low so a vsync already low at reset cannot make a tick.
      r_vsync_q      <= 1'b0;
      r_frame_tick   <= 1'b0;
      r_ring_phase   <= 8'd0;
      r_text_y       <= TextTop;
      r_text_visible <= 1'b1;
      r_swallow      <= 1'b0;
      r_state        <= StWait;
      r_paused       <= 1'b0;
      r_speed        <= SpeedX1;
      r_timer        <= 8'd0;
    end else begin
      r_vsync_q      <= bus.vsync;
      r_frame_tick   <= r_vsync_q & ~bus.vsync;
      r_ring_phase   <= w_ring_phase;
      r_text_y       <= w_text_y;
      r_text_visible <= w_text_visible;
      r_swallow      <= w_swallow;
      r_state        <= w_state;
      r_paused       <= w_paused;
      r_speed        <= w_speed;
      r_timer        <= w_timer;
    end
  end

  always_comb begin
    w_ring_phase   = r_ring_phase;
    w_text_y       = r_text_y;
    w_text_visible = r_text_visible;
    w_swallow      = r_swallow;
    w_state        = r_state;
    w_paused       = r_paused;
    w_speed        = r_speed;
    w_timer        = r_timer;
    w_step         = 8'd0;
    w_sum          = 11'd0;

    if (r_frame_tick) begin
      // Pause and speed resolve first; the rest of this tick uses the new values.
      if (w_press_pause) begin
        w_paused = ~r_paused;
      end
      if (w_press_speed) begin
        w_speed = speed_next(r_speed);
      end
      w_step = speed_step(w_speed);
      // 11-bit sum so the end-of-fall compare cannot be fooled by a wrap.
      w_sum  = {1'b0, r_text_y} + {3'b000, w_step};

      if (!w_paused) begin
        w_ring_phase = r_ring_phase + w_step;
        w_timer      = r_timer + 8'd1;
      end

      unique case (r_state)
        StWait: begin
          if (w_press_skip || (!w_paused && r_timer == WaitLast)) begin
            w_state = StFall;
            w_timer = 8'd0;
          end
        end
        StFall: begin
          if (w_press_skip || (!w_paused && w_sum >= TextEnd)) begin
            w_state        = StSwallow;
            w_text_y       = TextEnd[9:0];
            w_text_visible = 1'b0;
            w_swallow      = 1'b1;
            w_timer        = 8'd0;
          end else if (!w_paused) begin
            w_text_y = w_sum[9:0];
          end
        end
        StSwallow: begin
          if (w_press_skip || (!w_paused && r_timer == SwallowLast)) begin
            w_state        = StWait;
            w_text_y       = TextTop;
            w_text_visible = 1'b1;
            w_swallow      = 1'b0;
            w_timer        = 8'd0;
          end
        end
        default: begin
          w_state = StWait;
        end
      endcase
    end
  end

  assign bus.frame_tick   = r_frame_tick;
  assign bus.ring_phase   = r_ring_phase;
  assign bus.text_y       = r_text_y;
  assign bus.text_visible = r_text_visible;
  assign bus.swallow      = r_swallow;
  assign bus.scene        = r_state;
  assign bus.paused       = r_paused;
  assign bus.speed_sel    = r_speed;

endmodule

// File: tb/tb_scene_sequencer.sv
// tb_scene_sequencer: directed stimulus for scene_sequencer. Expected
// per-tick values are hand-computed and queued keyed by tick number; a
// monitor compares them in the cycle after each frame_tick.
module tb_scene_sequencer;

  typedef struct {
    int         tick;
    logic [1:0] scene;
    logic [9:0] text_y;
    logic [7:0] ring;
    logic       paused;
    logic [1:0] speed;
  } exp_t;

  logic clk;
  logic rst_n;

  scene_sequencer_if bus ();

  scene_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   checks    = 0;
  int   failures  = 0;
  int   mon_ticks = 0;
  int   stim_ticks = 0;
  logic prev_tick = 1'b0;
  exp_t sb[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_exp(input int tick, input int scene, input int text_y, input int ring,
                          input int paused, input int speed);
    exp_t e;
    e.tick   = tick;
    e.scene  = 2'(scene);
    e.text_y = 10'(text_y);
    e.ring   = 8'(ring);
    e.paused = 1'(paused);
    e.speed  = 2'(speed);
    sb.push_back(e);
  endtask

  // Monitor: registers update in the tick cycle, so compare on the next negedge.
  always @(negedge clk) begin
    if (prev_tick) begin
      check($sformatf("t%0d_tick_width", mon_ticks), int'(bus.frame_tick), 0);
      while (sb.size() > 0 && sb[0].tick < mon_ticks) begin
        exp_t s;
        s = sb.pop_front();
        checks++;
        failures++;
        $display("FAIL t%0d_missed: tick not seen, now at %0d", s.tick, mon_ticks);
      end
      if (sb.size() > 0 && sb[0].tick == mon_ticks) begin
        exp_t e;
        e = sb.pop_front();
        check($sformatf("t%0d_scene", e.tick), int'(bus.scene), int'(e.scene));
        check($sformatf("t%0d_text_y", e.tick), int'(bus.text_y), int'(e.text_y));
        check($sformatf("t%0d_ring", e.tick), int'(bus.ring_phase), int'(e.ring));
        check($sformatf("t%0d_paused", e.tick), int'(bus.paused), int'(e.paused));
        check($sformatf("t%0d_speed", e.tick), int'(bus.speed_sel), int'(e.speed));
        check($sformatf("t%0d_visible", e.tick), int'(bus.text_visible),
              (e.scene == 2'd2) ? 0 : 1);
        check($sformatf("t%0d_swallow", e.tick), int'(bus.swallow),
              (e.scene == 2'd2) ? 1 : 0);
      end
    end
    if (bus.frame_tick) begin
      mon_ticks++;
    end
    prev_tick = bus.frame_tick;
  end

  task automatic check_reset(input string pfx);
    check({pfx, "_frame_tick"}, int'(bus.frame_tick), 0);
    check({pfx, "_ring"}, int'(bus.ring_phase), 0);
    check({pfx, "_text_y"}, int'(bus.text_y), 20);
    check({pfx, "_visible"}, int'(bus.text_visible), 1);
    check({pfx, "_swallow"}, int'(bus.swallow), 0);
    check({pfx, "_scene"}, int'(bus.scene), 0);
    check({pfx, "_paused"}, int'(bus.paused), 0);
    check({pfx, "_speed"}, int'(bus.speed_sel), 0);
  endtask

  // One short frame: vsync low 2 cycles (tick applied by the end), high 4.
  task automatic do_frame();
    @(negedge clk);
    bus.vsync = 1'b0;
    repeat (2) @(negedge clk);
    bus.vsync = 1'b1;
    stim_ticks++;
    repeat (4) @(negedge clk);
  endtask

  task automatic run_to(input int t);
    while (stim_ticks < t) do_frame();
  endtask

  task automatic set_btn(input int which, input logic v);
    case (which)
      0:       bus.btn_pause = v;
      1:       bus.btn_speed = v;
      default: bus.btn_skip  = v;
    endcase
    repeat (3) @(negedge clk);  // let the synchronizer settle before the next tick
  endtask

  // Held over two ticks (action on the second), then released for two.
  task automatic press(input int which);
    set_btn(which, 1'b1);
    do_frame();
    do_frame();
    set_btn(which, 1'b0);
    do_frame();
    do_frame();
  endtask

  initial begin
    #1_000_000;
    checks++;
    failures++;
    $display("FAIL watchdog: time limit hit at tick %0d", mon_ticks);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    rst_n         = 1'b0;
    bus.vsync     = 1'b0;
    bus.btn_pause = 1'b0;
    bus.btn_speed = 1'b0;
    bus.btn_skip  = 1'b0;
    repeat (4) @(negedge clk);
    check_reset("rst");
    rst_n = 1'b1;
    // vsync already low after reset must not produce a tick.
    repeat (5) @(negedge clk);
    check("no_tick_after_reset", mon_ticks, 0);
    bus.vsync = 1'b1;
    repeat (3) @(negedge clk);

    // Three frames
    push_exp(1, 0, 20, 1, 0, 0);
    push_exp(3, 0, 20, 3, 0, 0);
    run_to(3);
    check("tick_count_3", mon_ticks, 3);

    // Full show at x1
    push_exp(127, 0, 20, 127, 0, 0);
    push_exp(128, 1, 20, 128, 0, 0);
    push_exp(129, 1, 21, 129, 0, 0);
    push_exp(347, 1, 239, 91, 0, 0);
    push_exp(348, 2, 240, 92, 0, 0);
    push_exp(411, 2, 240, 155, 0, 0);
    push_exp(412, 0, 20, 156, 0, 0);
    run_to(412);

    // Speed cycling during FALL
    push_exp(540, 1, 20, 28, 0, 0);
    push_exp(550, 1, 30, 38, 0, 0);
    run_to(550);
    push_exp(551, 1, 31, 39, 0, 0);
    push_exp(552, 1, 33, 41, 0, 1);
    push_exp(554, 1, 37, 45, 0, 1);
    press(1);
    push_exp(556, 1, 43, 51, 0, 2);
    push_exp(558, 1, 51, 59, 0, 2);
    press(1);
    push_exp(560, 1, 56, 64, 0, 0);
    push_exp(562, 1, 58, 66, 0, 0);
    press(1);

    // Pause for 50+ ticks, then resume
    push_exp(564, 1, 59, 67, 1, 0);
    push_exp(566, 1, 59, 67, 1, 0);
    press(0);
    push_exp(614, 1, 59, 67, 1, 0);
    run_to(614);
    push_exp(616, 1, 60, 68, 0, 0);
    push_exp(618, 1, 62, 70, 0, 0);
    press(0);

    // Skip in FALL
    push_exp(620, 2, 240, 72, 0, 0);
    push_exp(622, 2, 240, 74, 0, 0);
    press(2);
    push_exp(683, 2, 240, 135, 0, 0);
    push_exp(684, 0, 20, 136, 0, 0);
    run_to(684);

    // Skip while paused in WAIT
    push_exp(686, 0, 20, 137, 1, 0);
    push_exp(688, 0, 20, 137, 1, 0);
    press(0);
    push_exp(700, 0, 20, 137, 1, 0);
    run_to(700);
    push_exp(702, 1, 20, 137, 1, 0);
    push_exp(704, 1, 20, 137, 1, 0);
    press(2);
    push_exp(706, 1, 21, 138, 0, 0);
    push_exp(708, 1, 23, 140, 0, 0);
    press(0);

    // Pause in WAIT stretches WAIT by the paused ticks
    push_exp(924, 1, 239, 100, 0, 0);
    push_exp(925, 2, 240, 101, 0, 0);
    push_exp(988, 2, 240, 164, 0, 0);
    push_exp(989, 0, 20, 165, 0, 0);
    run_to(989);
    push_exp(991, 0, 20, 166, 1, 0);
    press(0);
    push_exp(1040, 0, 20, 166, 1, 0);
    run_to(1040);
    push_exp(1042, 0, 20, 167, 0, 0);
    press(0);
    push_exp(1167, 0, 20, 36, 0, 0);
    push_exp(1168, 1, 20, 37, 0, 0);
    run_to(1168);

    // Glitch: button seen on one tick only
    set_btn(1, 1'b1);
    do_frame();
    set_btn(1, 1'b0);
    push_exp(1172, 1, 24, 41, 0, 0);
    run_to(1172);

    // Leave speed at x2, then reset mid-FALL
    push_exp(1174, 1, 27, 44, 0, 1);
    push_exp(1176, 1, 31, 48, 0, 1);
    press(1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset("mid_rst");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    push_exp(1177, 0, 20, 1, 0, 0);
    run_to(1177);

    repeat (4) @(negedge clk);
    check("tick_count_total", mon_ticks, stim_ticks);
    check("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/scene_sequencer.md
# scene_sequencer

Frame-rate controller for the black-hole demoscene renderer. It detects the start of each frame from the VGA vsync and debounces three user buttons taken from ui_in. It then runs the show's scene state machine and issues per-frame animation parameters to the combinational pixel datapath: ring texture phase, text Y position, text visibility and a swallow-flash flag. All outputs change only on frame boundaries, so the datapath sees stable values for a whole frame.

## Interface
- WAIT_FRAMES, 128: frames spent in WAIT.
- SWALLOW_FRAMES, 64: frames spent in SWALLOW.
- TEXT_Y_TOP, 20: text Y position in WAIT.
- TEXT_Y_END, 240: text Y at which FALL ends (screen centre).
- clk  in  1  pixel clock (~25 MHz). One clock; reset is synchronous and active-low.
- rst_n  in  1  synchronous active-low reset.
- vsync  in  1  active-low vertical sync from the timing generator.
- btn_pause  in  1  asynchronous button (ui_in[0]); toggles pause.
- btn_speed  in  1  asynchronous button (ui_in[1]); cycles the speed step.
- btn_skip  in  1  asynchronous button (ui_in[2]); forces the next state.
- frame_tick  out  1  one-cycle pulse per frame.
- ring_phase  out  8  ring texture phase, subtracted from the radius bits by the datapath.
- text_y  out  10  top row of the "UW" text.
- text_visible  out  1  gates text drawing.
- swallow  out  1  high throughout SWALLOW; the datapath brightens the halo.
- scene  out  2  current state: 0=WAIT, 1=FALL, 2=SWALLOW.
- paused  out  1  pause status.
- speed_sel  out  2  0=x1, 1=x2, 2=x4; 3 is never produced.

## Operation
- Frame detect: vsync_q <= vsync; frame_tick <= vsync_q & ~vsync. This gives one pulse per vsync falling edge.
- Buttons:
  - Each button passes through a 2-FF synchronizer.
  - The synchronized level is sampled only on frame_tick.
  - The debounced level changes only when two consecutive tick samples agree.
  - An action fires on the tick where the debounced level goes 0->1.
- Actions on a tick are applied in this order: pause, then speed, then skip/state update.
  - pause: paused <= ~paused.
  - speed: speed_sel goes 0->1->2->0. step = 1 << speed_sel.
  - The new paused and speed_sel values are used in the same tick's update.
- Per tick, when not paused:
  - ring_phase <= ring_phase + step, modulo 256.
  - The state timer advances.
- When paused, ring_phase, text_y and the timer hold.
- skip acts even while paused.
- States (timer is 8 bits, cleared on every state entry):
  - WAIT: text_y=TEXT_Y_TOP, text_visible=1. When the timer reaches WAIT_FRAMES-1 on a tick, go to FALL on that tick.
  - FALL: text_y <= text_y + step. If the sum is >= TEXT_Y_END, set text_y=TEXT_Y_END, clear text_visible and go to SWALLOW.
  - SWALLOW: swallow=1, text_visible=0. When the timer reaches SWALLOW_FRAMES-1, go to WAIT with text_y=TEXT_Y_TOP and text_visible=1.
  - skip: take the normal exit of the current state on that tick, with the same output assignments as the normal exit.
- Width rule: the text_y add is done in 11 bits before the compare, so it never wraps.

## Timing
- Reset values: frame_tick=0, ring_phase=0, text_y=20, text_visible=1, swallow=0, scene=WAIT, paused=0, speed_sel=0, timer=0. All synchronizers, sample registers and debounced levels are 0.
- Reset asserted mid-frame or mid-state returns every register to its reset value on the next edge. No tick is generated until a fresh vsync falling edge is seen.
- frame_tick is high in the cycle after the cycle in which vsync is first sampled low.
- All state and parameter registers update in the cycle where frame_tick=1, so new values are visible the following cycle. That is well inside vertical blanking.
- Button latency: a press needs 2 synchronizer cycles, then two consecutive ticks sampled high. The action lands on the second of those ticks.
- Frame counts at x1 with no pause:
  - WAIT lasts exactly 128 ticks.
  - FALL lasts 220 ticks.
  - SWALLOW lasts 64 ticks.
- A speed change mid-FALL uses the new step from that tick onward.

## Structure
- Package scene_pkg holds:
  - the state enum (WAIT, FALL, SWALLOW);
  - the default constants TEXT_Y_TOP, TEXT_Y_END, WAIT_FRAMES and SWALLOW_FRAMES;
  - the speed_sel encoding.
- One sub-module, btn_debounce, contains the synchronizer, the tick-sampled agreement filter and the rising-edge output. It is instantiated three times.

## Test plan
- Reset then 3 vsync falling edges -> exactly 3 one-cycle frame_tick pulses; ring_phase=3; text_y=20; scene=WAIT.
- Run from reset at x1 -> FALL at tick 128; text_y=21 at tick 129; SWALLOW at tick 348 with text_y=240 and text_visible=0; WAIT at tick 412 with text_y=20.
- Hold btn_speed high for 2 ticks during FALL -> speed_sel=1; text_y and ring_phase step by 2. Two more presses -> x4, then back to x1.
- btn_pause press -> ring_phase, text_y and timer frozen across 50 ticks. A second press resumes from the identical values.
- btn_skip while paused in WAIT -> FALL on the action tick. Skip in FALL -> text_y=240, swallow=1.
- Button pulse sampled on only 1 tick (glitch) -> no action. Reset asserted mid-FALL -> all outputs at reset values the next cycle.
